// File: rtl/traditional_mult8_aor_enc32.sv
// Registered 8x8 unsigned multiplier, partial products locked by 32 AND/OR key gates.
// Define AOR_LOCK_EN to insert the key gates; otherwise keyinput is ignored.
module traditional_mult8_aor_enc32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  operand1_i,
    input  logic [7:0]  operand2_i,
    input  logic [31:0] keyinput,
    output logic [15:0] result_o
);

    logic [7:0]  pp  [8];
    logic [7:0]  lpp [8];
    logic [15:0] sum;

    always_comb begin
        for (int j = 0; j < 8; j++) begin
            pp[j] = operand1_i & {8{operand2_i[j]}};
        end
    end

`ifdef AOR_LOCK_EN
    localparam logic [31:0] K0 = 32'hF5852662;

    // Locked positions are the checkerboard cells where column parity matches row parity.
    for (genvar j = 0; j < 8; j++) begin : g_row
        for (genvar i = 0; i < 8; i++) begin : g_col
            if ((i % 2) == (j % 2)) begin : g_lock
                localparam int K = (i / 2) * 8 + j;
                if (K0[K]) begin : g_and
                    assign lpp[j][i] = pp[j][i] & keyinput[K];
                end else begin : g_or
                    assign lpp[j][i] = pp[j][i] | keyinput[K];
                end
            end else begin : g_pass
                assign lpp[j][i] = pp[j][i];
            end
        end
    end
`else
    logic unused_key;
    assign unused_key = ^keyinput;

    always_comb begin
        for (int j = 0; j < 8; j++) begin
            lpp[j] = pp[j];
        end
    end
`endif

    always_comb begin
        sum = 16'h0000;
        for (int j = 0; j < 8; j++) begin
            sum = sum + (16'(lpp[j]) << j);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_o <= 16'h0000;
        end else begin
            result_o <= sum;
        end
    end

endmodule

// File: tb/tb_traditional_mult8_aor_enc32.sv
// Directed and random checks for traditional_mult8_aor_enc32.
// Wrong-key expectations follow whether AOR_LOCK_EN is defined.
module tb_traditional_mult8_aor_enc32;

    localparam logic [31:0] K0 = 32'hF5852662;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [31:0] key;
    logic [15:0] result;

    int vectors = 0;
    int miscompares = 0;

    traditional_mult8_aor_enc32 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .operand1_i (a),
        .operand2_i (b),
        .keyinput   (key),
        .result_o   (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
    } vec_t;

    vec_t tbl [7];

    logic [15:0] exp_ones;
    logic [15:0] exp_nolock;

    initial begin
        tbl[0] = '{8'h29, 8'h7A, 16'h138A};
        tbl[1] = '{8'h11, 8'h11, 16'h0121};
        tbl[2] = '{8'h81, 8'h1C, 16'h0E1C};
        tbl[3] = '{8'h89, 8'hFF, 16'h8877};
        tbl[4] = '{8'h55, 8'hAA, 16'h3872};
        tbl[5] = '{8'h80, 8'h80, 16'h4000};
        tbl[6] = '{8'hAB, 8'h00, 16'h0000};
`ifdef AOR_LOCK_EN
        exp_ones = 16'h15E9;
`else
        exp_ones = 16'h0000;
`endif

        rst_n = 1'b0;
        a = 8'hFF;
        b = 8'hFF;
        key = K0;
        step();
        check("rst_edge0", result, 16'h0000);
        step();
        check("rst_edge1", result, 16'h0000);
        rst_n = 1'b1;
        step();
        check("rst_release", result, 16'hFE01);

        for (int n = 0; n < 7; n++) begin
            a = tbl[n].a;
            b = tbl[n].b;
            step();
            check($sformatf("k0_vec%0d", n), result, tbl[n].p);
        end

        a = 8'h00;
        b = 8'h00;
        key = 32'hFFFFFFFF;
        step();
        check("key_ones", result, exp_ones);
        key = K0;
        step();
        check("key_restore", result, 16'h0000);
        key = 32'h00000000;
        step();
        check("key_zeros", result, 16'h0000);

`ifndef AOR_LOCK_EN
        exp_nolock = 16'h8877;
        a = 8'h89;
        b = 8'hFF;
        step();
        check("nolock_key0", result, exp_nolock);
`endif

        key = K0;
        for (int n = 0; n < 10000; n++) begin
            logic [15:0] exp;
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            rst_n = ($urandom_range(0, 63) != 0);
            exp = rst_n ? 16'(a) * 16'(b) : 16'h0000;
            step();
            check("random", result, exp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
